pipeline_hazard_ctrl: RTL

Central sequencer for the five-stage pipeline latches: fetch/decode, decode/execute, execute/memory and memory/writeback. Each cycle it decides per latch whether to advance (`en_*`), insert a bubble (`flush_*`) or hold. It also gates the PC. It tracks outstanding data-memory accesses and the halt drain with a small FSM, so that no latch ever advances on a stale stage.

---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC.
// Define PIPE_PERF_EN to add the stall_cycles / flush_events performance counters.
module pipeline_hazard_ctrl #(
    parameter int REGADDR_W = 5
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 dmemREN_mem,
    input  logic                 dmemWEN_mem,
    input  logic                 MemRead_ex,
    input  logic [REGADDR_W-1:0] regWSEL_ex,
    input  logic [REGADDR_W-1:0] rs_id,
    input  logic [REGADDR_W-1:0] rt_id,
    input  logic                 branch_taken_mem,
    input  logic                 halt_wb,
    output logic                 en_fd,
    output logic                 en_dx,
    output logic                 en_xm,
    output logic                 en_mw,
    output logic                 flush_fd,
    output logic                 flush_dx,
    output logic                 flush_xm,
    output logic                 flush_mw,
    output logic                 pc_en,
    output logic                 halted
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_ipend;

    logic w_dreq, w_lu, w_iv;
    logic w_eval, w_row3;
    logic w_en_fd, w_en_dx, w_en_xm, w_en_mw;
    logic w_flush_fd, w_flush_dx, w_flush_xm, w_flush_mw;
    logic w_pc_en;

    assign w_dreq = dmemREN_mem | dmemWEN_mem;
    assign w_lu   = MemRead_ex & (regWSEL_ex != '0) &
                    ((regWSEL_ex == rs_id) | (regWSEL_ex == rt_id));
    assign w_iv   = ihit | r_ipend;

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_eval       = 1'b0;
        w_row3       = 1'b0;
        w_en_fd      = 1'b0;
        w_en_dx      = 1'b0;
        w_en_xm      = 1'b0;
        w_en_mw      = 1'b0;
        w_flush_fd   = 1'b0;
        w_flush_dx   = 1'b0;
        w_flush_xm   = 1'b0;
        w_flush_mw   = 1'b0;
        w_pc_en      = 1'b0;

        case (r_state)
            RUN: begin
                if (halt_wb)              w_next_state = HALT;
                else if (w_dreq && !dhit) w_next_state = DWAIT;
                else                      w_eval       = 1'b1;
            end
            DWAIT: begin
                if (dhit) begin
                    w_next_state = RUN;
                    w_eval       = 1'b1;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = RUN;
        endcase

        // Shared decision table for a free-running RUN cycle and the DWAIT release cycle.
        if (w_eval) begin
            if (branch_taken_mem) begin
                w_row3     = 1'b1;
                w_flush_fd = 1'b1;
                w_flush_dx = 1'b1;
                w_flush_xm = 1'b1;
                w_en_mw    = 1'b1;
                w_pc_en    = 1'b1;
            end else if (w_lu) begin
                w_flush_dx = 1'b1;
                w_en_xm    = 1'b1;
                w_en_mw    = 1'b1;
            end else if (!w_iv) begin
                w_flush_fd = 1'b1;
                w_en_dx    = 1'b1;
                w_en_xm    = 1'b1;
                w_en_mw    = 1'b1;
            end else begin
                w_en_fd    = 1'b1;
                w_en_dx    = 1'b1;
                w_en_xm    = 1'b1;
                w_en_mw    = 1'b1;
                w_pc_en    = 1'b1;
            end
        end
    end

    // Reset gates every control output so nothing advances while nRST is low.
    assign en_fd    = w_en_fd    & nRST;
    assign en_dx    = w_en_dx    & nRST;
    assign en_xm    = w_en_xm    & nRST;
    assign en_mw    = w_en_mw    & nRST;
    assign flush_fd = w_flush_fd & nRST;
    assign flush_dx = w_flush_dx & nRST;
    assign flush_xm = w_flush_xm & nRST;
    assign flush_mw = w_flush_mw & nRST;
    assign pc_en    = w_pc_en    & nRST;
    assign halted   = (r_state == HALT);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
            r_ipend <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // A fetch completed while IF/ID was held is remembered until it is consumed or squashed.
            if (en_fd || flush_fd) r_ipend <= 1'b0;
            else if (ihit)         r_ipend <= 1'b1;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (r_state != HALT) begin
            if (!pc_en) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_row3) r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
